// File: rtl/execute_stage_mdu_pkg.sv
// rtl/execute_stage_mdu_pkg.sv - shared encodings and MDU state type for the execute stage
package execute_stage_mdu_pkg;

    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/execute_stage_mdu_mdu_iter.sv
// rtl/execute_stage_mdu_mdu_iter.sv - iterative RV32M multiply/divide unit with start/done handshake
module mdu_iter
    import execute_stage_mdu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W    = $clog2(XLEN + MUL_LATENCY) + 1;
    localparam int MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    mdu_state_e state, state_nxt;

    logic [2:0]      op_r;
    logic [XLEN-1:0] a_r, b_r;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic            div0_r, ovf_r;

    logic            start_signed, a_neg_in, b_neg_in;
    logic [XLEN:0]   shifted, diff;

    assign start_signed = op[2] & ~op[0];
    assign a_neg_in     = start_signed & a[XLEN-1];
    assign b_neg_in     = start_signed & b[XLEN-1];

    // one restoring step: shift next dividend bit into the partial remainder
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    if (op[2]) begin
                        state_nxt = MDU_DIV;
                    end else if (MUL_LATENCY == 1) begin
                        state_nxt = MDU_DONE;
                    end else begin
                        state_nxt = MDU_MUL;
                    end
                end
            end
            MDU_MUL:  if (cnt == CNT_W'(MUL_LAST)) state_nxt = MDU_DONE;
            MDU_DIV:  if (div0_r || ovf_r || cnt == CNT_W'(XLEN - 1)) state_nxt = MDU_DONE;
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
        if (flush) begin
            state_nxt = MDU_IDLE;
        end
    end

    always_comb begin
        busy = (state != MDU_IDLE);
        done = (state == MDU_DONE);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_neg_in ? -a : a;
            dvs    <= b_neg_in ? -b : b;
            div0_r <= op[2] & (b == '0);
            ovf_r  <= start_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
        end else if (state == MDU_MUL) begin
            cnt <= cnt + CNT_W'(1);
        end else if (state == MDU_DIV) begin
            cnt <= cnt + CNT_W'(1);
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // sign-extending both operands to 2*XLEN makes one modular multiply serve all four MUL ops
    logic            a_sx, b_sx, signed_r;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] q_fix, r_fix;

    assign a_sx  = (op_r[1:0] != 2'b11) & a_r[XLEN-1];
    assign b_sx  = (op_r[1:0] == 2'b01) & b_r[XLEN-1];
    assign a_ext = {{XLEN{a_sx}}, a_r};
    assign b_ext = {{XLEN{b_sx}}, b_r};
    assign prod  = a_ext * b_ext;

    assign signed_r = ~op_r[0];

    always_comb begin
        q_fix = (signed_r & (a_r[XLEN-1] ^ b_r[XLEN-1])) ? -quo : quo;
        r_fix = (signed_r & a_r[XLEN-1]) ? -rem : rem;
        if (div0_r) begin
            q_fix = '1;
            r_fix = a_r;
        end else if (ovf_r) begin
            q_fix = a_r;
            r_fix = '0;
        end
        if (op_r[2]) begin
            result = op_r[1] ? r_fix : q_fix;
        end else if (op_r[1:0] == 2'b00) begin
            result = prod[XLEN-1:0];
        end else begin
            result = prod[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/execute_stage_mdu.sv
// rtl/execute_stage_mdu.sv - execute stage: ALU, branch compare and stalling RV32M unit
module execute_stage_mdu
    import execute_stage_mdu_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          MUL_LATENCY = 2,
    parameter logic [31:0] NOP_INST    = RV_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] data_a,
    input  logic [XLEN-1:0] data_b,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] imm,
    input  logic            asel,
    input  logic            bsel,
    input  logic [3:0]      alu_sel,
    input  logic            br_un,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic            br_eq,
    output logic            br_lt,
    output logic [XLEN-1:0] alu_out,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_store_data,
    output logic            mdu_busy
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] alu_a, alu_b;
    logic [SHW-1:0]  shamt;

    assign alu_a = asel ? pc_in : data_a;
    assign alu_b = bsel ? imm : data_b;
    assign shamt = alu_b[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            ALU_ADD:   alu_out = alu_a + alu_b;
            ALU_SUB:   alu_out = alu_a - alu_b;
            ALU_SLL:   alu_out = alu_a << shamt;
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:   alu_out = alu_a ^ alu_b;
            ALU_SRL:   alu_out = alu_a >> shamt;
            ALU_SRA:   alu_out = $signed(alu_a) >>> shamt;
            ALU_OR:    alu_out = alu_a | alu_b;
            ALU_AND:   alu_out = alu_a & alu_b;
            ALU_PASSB: alu_out = alu_b;
            default:   alu_out = '0;
        endcase
    end

    assign br_eq = (data_a == data_b);
    assign br_lt = br_un ? (data_a < data_b) : ($signed(data_a) < $signed(data_b));

    logic            accept, mdu_start, mdu_done;
    logic [XLEN-1:0] mdu_result;
    logic [XLEN-1:0] buf_pc, buf_store;
    logic [31:0]     buf_inst;

    assign in_ready  = ~mdu_busy;
    assign accept    = in_valid & in_ready & ~flush;
    assign mdu_start = accept & md_en;

    mdu_iter #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mdu_iter (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (mdu_start),
        .op     (md_op),
        .a      (data_a),
        .b      (data_b),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    always_ff @(posedge clk) begin
        if (mdu_start) begin
            buf_pc    <= pc_in;
            buf_inst  <= inst_in;
            buf_store <= data_b;
        end
    end

    // output slot: a bubble keeps the old payload but marks it invalid and shows a NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_pc         <= '0;
            out_inst       <= NOP_INST;
            out_store_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
        end else if (mdu_done) begin
            out_valid      <= 1'b1;
            out_result     <= mdu_result;
            out_pc         <= buf_pc;
            out_inst       <= buf_inst;
            out_store_data <= buf_store;
        end else if (accept && !md_en) begin
            out_valid      <= 1'b1;
            out_result     <= alu_out;
            out_pc         <= pc_in;
            out_inst       <= inst_in;
            out_store_data <= data_b;
        end else begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb/tb_execute_stage_mdu.sv - directed table-driven bench for execute_stage_mdu
module tb_execute_stage_mdu;
    import execute_stage_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] data_a, data_b, pc_in, inst_in, imm;
    logic        asel, bsel, br_un, md_en;
    logic [3:0]  alu_sel;
    logic [2:0]  md_op;
    logic        br_eq, br_lt, out_valid, mdu_busy;
    logic [31:0] alu_out, out_result, out_pc, out_inst, out_store_data;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    execute_stage_mdu #(.XLEN(32), .MUL_LATENCY(2), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .pc_in(pc_in), .inst_in(inst_in), .imm(imm),
        .asel(asel), .bsel(bsel), .alu_sel(alu_sel), .br_un(br_un), .md_en(md_en),
        .md_op(md_op), .br_eq(br_eq), .br_lt(br_lt), .alu_out(alu_out),
        .out_valid(out_valid), .out_result(out_result), .out_pc(out_pc),
        .out_inst(out_inst), .out_store_data(out_store_data), .mdu_busy(mdu_busy)
    );

    typedef struct {
        logic        md_en;
        logic [2:0]  md_op;
        logic [3:0]  alu_sel;
        logic        asel;
        logic        bsel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic me, input logic [2:0] mop, input logic [3:0] as,
                                input logic sa, input logic sb, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] pc, input logic [31:0] im,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.md_en = me; v.md_op = mop; v.alu_sel = as; v.asel = sa; v.bsel = sb;
        v.a = a; v.b = b; v.pc = pc; v.imm = im; v.inst = 32'h0;
        v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        md_en = v.md_en; md_op = v.md_op; alu_sel = v.alu_sel; asel = v.asel; bsel = v.bsel;
        data_a = v.a; data_b = v.b; pc_in = v.pc; imm = v.imm; inst_in = v.inst;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check($sformatf("v%0d in_ready", idx), in_ready, !v.md_en);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d result", idx), out_result, v.exp);
        check($sformatf("v%0d pc", idx), out_pc, v.pc);
        check($sformatf("v%0d inst", idx), out_inst, v.inst);
        check($sformatf("v%0d store", idx), out_store_data, v.b);
        @(posedge clk);
        #1;
        check($sformatf("v%0d bubble valid", idx), out_valid, 1'b0);
        check($sformatf("v%0d bubble inst", idx), out_inst, 32'h13);
    endtask

    logic [31:0] br_tab_a [4];
    logic [31:0] br_tab_b [4];
    logic        br_tab_u [4];
    logic [1:0]  br_tab_e [4];

    initial begin
        vec_t v;
        int   seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        data_a = '0; data_b = '0; pc_in = '0; inst_in = '0; imm = '0;
        asel = 1'b0; bsel = 1'b0; br_un = 1'b0; md_en = 1'b0; alu_sel = '0; md_op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_result", out_result, 32'h0);
        check("rst out_pc", out_pc, 32'h0);
        check("rst out_inst", out_inst, 32'h13);
        check("rst out_store", out_store_data, 32'h0);
        check("rst mdu_busy", mdu_busy, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        rst = 1'b0;

        br_tab_a = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        br_tab_b = '{32'd5, 32'd1, 32'd1, 32'd9};
        br_tab_u = '{1'b0, 1'b0, 1'b1, 1'b1};
        br_tab_e = '{2'b10, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_a = br_tab_a[i]; data_b = br_tab_b[i]; br_un = br_tab_u[i];
            #1;
            check($sformatf("br%0d eq/lt", i), {br_eq, br_lt}, br_tab_e[i]);
        end
        br_un = 1'b0;

        vecs.push_back(mk(0, MD_MUL,  ALU_ADD,  0, 0, 32'd5, 32'd7, 32'h100, 32'h0, 32'd12, 0));
        vecs.push_back(mk(0, MD_MUL,  ALU_SUB,  0, 0, 32'd5, 32'd7, 32'h104, 32'h0, 32'hFFFF_FFFE, 0));
        vecs.push_back(mk(0, MD_MUL,  ALU_ADD,  1, 1, 32'd1, 32'd2, 32'h200, 32'h20, 32'h220, 0));
        vecs.push_back(mk(0, MD_MUL,  ALU_SLT,  0, 0, 32'hFFFF_FFFF, 32'd1, 32'h10C, 32'h0, 32'd1, 0));
        vecs.push_back(mk(0, MD_MUL,  ALU_SLTU, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h110, 32'h0, 32'd0, 0));
        vecs.push_back(mk(0, MD_MUL,  ALU_SRA,  0, 1, 32'h8000_0000, 32'd9, 32'h114, 32'd4, 32'hF800_0000, 0));
        vecs.push_back(mk(1, MD_MUL,    ALU_ADD, 0, 0, 32'd6, 32'd7, 32'h118, 32'h0, 32'd42, 2));
        vecs.push_back(mk(1, MD_MULH,   ALU_ADD, 0, 0, 32'h8000_0000, 32'd2, 32'h11C, 32'h0, 32'hFFFF_FFFF, 2));
        vecs.push_back(mk(1, MD_MULHU,  ALU_ADD, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h120, 32'h0, 32'hFFFF_FFFE, 2));
        vecs.push_back(mk(1, MD_MULHSU, ALU_ADD, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h124, 32'h0, 32'hFFFF_FFFF, 2));
        vecs.push_back(mk(1, MD_DIV,  ALU_ADD, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'h128, 32'h0, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(1, MD_REM,  ALU_ADD, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'h12C, 32'h0, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(1, MD_DIV,  ALU_ADD, 0, 0, 32'd7, 32'hFFFF_FFFE, 32'h130, 32'h0, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(1, MD_REM,  ALU_ADD, 0, 0, 32'd7, 32'hFFFF_FFFE, 32'h134, 32'h0, 32'd1, 33));
        vecs.push_back(mk(1, MD_DIVU, ALU_ADD, 0, 0, 32'd100, 32'd7, 32'h138, 32'h0, 32'd14, 33));
        vecs.push_back(mk(1, MD_REMU, ALU_ADD, 0, 0, 32'd100, 32'd7, 32'h13C, 32'h0, 32'd2, 33));
        vecs.push_back(mk(1, MD_DIVU, ALU_ADD, 0, 0, 32'd9, 32'd0, 32'h140, 32'h0, 32'hFFFF_FFFF, 2));
        vecs.push_back(mk(1, MD_REMU, ALU_ADD, 0, 0, 32'd9, 32'd0, 32'h144, 32'h0, 32'd9, 2));
        vecs.push_back(mk(1, MD_DIV,  ALU_ADD, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h148, 32'h0, 32'h8000_0000, 2));
        vecs.push_back(mk(1, MD_REM,  ALU_ADD, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h14C, 32'h0, 32'd0, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            v.inst = 32'h0000_0033 | (i << 7);
            run_vec(v, i);
        end

        // flush a divide after ten iterations
        v = mk(1, MD_DIVU, ALU_ADD, 0, 0, 32'd100, 32'd7, 32'h300, 32'h0, 32'd14, 33);
        v.inst = 32'h0220_00B3;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush mdu_busy", mdu_busy, 1'b0);
        check("flush in_ready", in_ready, 1'b1);
        check("flush out_valid", out_valid, 1'b0);
        check("flush out_inst", out_inst, 32'h13);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush no stale result", seen, 0);
        v = mk(0, MD_MUL, ALU_ADD, 0, 0, 32'd2, 32'd3, 32'h304, 32'h0, 32'd5, 0);
        v.inst = 32'h0031_01B3;
        run_vec(v, 100);

        // flush while idle suppresses an accept
        @(negedge clk);
        v = mk(0, MD_MUL, ALU_ADD, 0, 0, 32'd8, 32'd8, 32'h400, 32'h0, 32'd16, 0);
        drive(v);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle flush out_valid", out_valid, 1'b0);
        check("idle flush result held", out_result, 32'd5);

        // reset in the middle of a multiply
        v = mk(1, MD_MUL, ALU_ADD, 0, 0, 32'd3, 32'd3, 32'h500, 32'h0, 32'd9, 2);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mul busy", mdu_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", mdu_busy, 1'b0);
        check("midrst out_result", out_result, 32'h0);
        check("midrst out_inst", out_inst, 32'h13);
        @(posedge clk);
        #1;
        check("midrst out_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
